// File: rtl/ps2_command_receiver_if.sv
// Keyboard pin inputs and display-path command outputs of ps2_command_receiver.
// The slave modport is the receiver side. The master modport is the keyboard/consumer side.
interface ps2_command_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] character;
    logic       char_check;
    logic       colour_check;
    logic       move_check;
    logic [1:0] mode;
    logic       frame_error;

    modport master (
        output ps2_clk, ps2_data,
        input  character, char_check, colour_check, move_check, mode, frame_error
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output character, char_check, colour_check, move_check, mode, frame_error
    );
endinterface

// File: rtl/ps2_command_receiver.sv
// PS/2 keyboard frame receiver. It decodes make codes into mode changes and
// into character/colour/move strobes for the display controller.
module ps2_command_receiver #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 1000
) (
    input logic                   clk,
    input logic                   reset,
    ps2_command_receiver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] KEY_F1   = 8'h05;
    localparam logic [7:0] KEY_F2   = 8'h06;
    localparam logic [7:0] KEY_F3   = 8'h04;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;
    typedef enum logic [1:0] {MODE_CHAR, MODE_COLOUR, MODE_MOVE} mode_e;

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    mode_e         mode_q, mode_d;
    logic [7:0]    char_q, char_d;
    logic          char_chk_q, char_chk_d;
    logic          colour_chk_q, colour_chk_d;
    logic          move_chk_q, move_chk_d;
    logic          frame_err_q, frame_err_d;

    logic       ps2_fall;
    logic       frame_ok;
    logic [7:0] code;

    assign ps2_fall = clk_prev_q & ~clk_sync_q;
    // shift_q holds: [7:0] data, [8] odd parity, [9] stop.
    assign frame_ok = (^shift_q[8:0]) & shift_q[9];
    assign code     = shift_q[7:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= TMO_RELOAD;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            mode_q       <= MODE_CHAR;
            char_q       <= '0;
            char_chk_q   <= 1'b0;
            colour_chk_q <= 1'b0;
            move_chk_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= bus.ps2_clk;
            clk_sync_q   <= clk_meta_q;
            clk_prev_q   <= clk_sync_q;
            data_meta_q  <= bus.ps2_data;
            data_sync_q  <= data_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            mode_q       <= mode_d;
            char_q       <= char_d;
            char_chk_q   <= char_chk_d;
            colour_chk_q <= colour_chk_d;
            move_chk_q   <= move_chk_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        mode_d       = mode_q;
        char_d       = char_q;
        char_chk_d   = 1'b0;
        colour_chk_d = 1'b0;
        move_chk_d   = 1'b0;
        frame_err_d  = 1'b0;

        if (ps2_fall) tmo_d = TMO_RELOAD;

        unique case (state_q)
            IDLE: begin
                // A falling edge with data high is not a start bit, so it is ignored silently.
                if (ps2_fall && !data_sync_q) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ps2_fall) begin
                    shift_d   = {data_sync_q, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = CHECK;
                end else if (tmo_q == '0) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end else if (code == CODE_EXT) begin
                    ext_d = 1'b1;
                end else if (code == CODE_BRK) begin
                    brk_d = 1'b1;
                end else if (ext_q || brk_q) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (code == KEY_F1) begin
                    mode_d = MODE_CHAR;
                end else if (code == KEY_F2) begin
                    mode_d = MODE_COLOUR;
                end else if (code == KEY_F3) begin
                    mode_d = MODE_MOVE;
                end else begin
                    char_d = code;
                    case (mode_q)
                        MODE_CHAR:   char_chk_d   = 1'b1;
                        MODE_COLOUR: colour_chk_d = 1'b1;
                        MODE_MOVE:   move_chk_d   = 1'b1;
                        default:     ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.character    = char_q;
    assign bus.char_check   = char_chk_q;
    assign bus.colour_check = colour_chk_q;
    assign bus.move_check   = move_chk_q;
    assign bus.mode         = mode_q;
    assign bus.frame_error  = frame_err_q;
endmodule

// File: tb/tb_ps2_command_receiver.sv
// Bench for ps2_command_receiver. It uses directed and random PS/2 frames.
// Each frame's outputs are compared with a frame-level reference model of the command rules.
module tb_ps2_command_receiver;
    localparam int TIMEOUT = 100;
    localparam int HALF    = 6;   // clk cycles per ps2_clk half period
    localparam int SETTLE  = 12;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_command_receiver_if bus ();

    ps2_command_receiver #(
        .CLK_HZ        (100_000),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Event log: kind 0 char, 1 colour, 2 move, 3 frame error.
    typedef struct {
        int         kind;
        logic [7:0] chr;
        int         cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc       = 0;
    int  multi_hot = 0;
    int  last_fall = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($countones({bus.char_check, bus.colour_check, bus.move_check, bus.frame_error}) > 1)
            multi_hot <= multi_hot + 1;
        if (bus.char_check)   evq.push_back('{0, bus.character, cyc});
        if (bus.colour_check) evq.push_back('{1, bus.character, cyc});
        if (bus.move_check)   evq.push_back('{2, bus.character, cyc});
        if (bus.frame_error)  evq.push_back('{3, bus.character, cyc});
    end

    // Reference model state.
    logic [1:0] m_mode;
    logic       m_ext, m_brk;
    logic [7:0] m_char;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'd0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_char = 8'h00;
    endtask

    // The frame-level rule table gives the expected event: -1 none, 0..2 strobe, 3 error.
    task automatic model_frame(input logic [7:0] c, input bit good, output int kind);
        kind = -1;
        if (!good) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            kind  = 3;
        end else if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else if (m_ext || m_brk) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (c == 8'h05) m_mode = 2'd0;
        else if (c == 8'h06) m_mode = 2'd1;
        else if (c == 8'h04) m_mode = 2'd2;
        else begin
            m_char = c;
            kind   = int'(m_mode);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^c) ^ bad_par;
        return {~bad_stop, par, c, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall   = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) ps2_bit(bits[i]);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " character"}, bus.character, m_char);
        check({tag, " mode"}, bus.mode, m_mode);
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] c, input bit bad_par, input bit bad_stop);
        int kind;
        evq.delete();
        send_bits(make_frame(c, bad_par, bad_stop), 0, 10);
        repeat (SETTLE) @(negedge clk);
        model_frame(c, !(bad_par || bad_stop), kind);
        check({tag, " events"}, evq.size(), (kind < 0) ? 0 : 1);
        if (kind >= 0 && evq.size() == 1) begin
            check({tag, " kind"}, evq[0].kind, kind);
            // The raw fall is driven at a negedge. Two sync flops then detect it 2 cycles later, and the output is 2 cycles after that.
            check({tag, " latency"}, evq[0].cyc - last_fall, 4);
            if (kind < 3) check({tag, " strobe char"}, evq[0].chr, c);
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  c;
        int          r;
        bit          bp, bs;
        int          exp_err;

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst character", bus.character, 8'h00);
        check("rst mode", bus.mode, 2'd0);
        check("rst char_check", bus.char_check, 1'b0);
        check("rst colour_check", bus.colour_check, 1'b0);
        check("rst move_check", bus.move_check, 1'b0);
        check("rst frame_error", bus.frame_error, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        frame_and_check("char 1C", 8'h1C, 0, 0);
        frame_and_check("F2", 8'h06, 0, 0);
        frame_and_check("colour 2D", 8'h2D, 0, 0);
        frame_and_check("brk F0", 8'hF0, 0, 0);
        frame_and_check("brk 2D", 8'h2D, 0, 0);
        frame_and_check("after brk 2D", 8'h2D, 0, 0);
        frame_and_check("ext E0", 8'hE0, 0, 0);
        frame_and_check("ext 75", 8'h75, 0, 0);
        frame_and_check("bad parity", 8'h1C, 1, 0);
        frame_and_check("bad stop", 8'h1C, 0, 1);
        frame_and_check("good 1C", 8'h1C, 0, 0);

        // A pending prefix must be cleared by the timeout so the next F3 still sets the mode.
        frame_and_check("pre-tmo E0", 8'hE0, 0, 0);
        evq.delete();
        send_bits(make_frame(8'h3A, 0, 0), 0, 4);
        repeat (TIMEOUT + 20) @(negedge clk);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("tmo events", evq.size(), 1);
        if (evq.size() == 1) begin
            check("tmo kind", evq[0].kind, 3);
            // There are 100 idle cycles in SHIFT after the reload at detect, then the error is registered.
            check("tmo latency", evq[0].cyc - last_fall, TIMEOUT + 4);
        end
        frame_and_check("F3 after tmo", 8'h04, 0, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0:       c = 8'h05;
                1:       c = 8'h06;
                2:       c = 8'h04;
                3:       c = 8'hF0;
                4:       c = 8'hE0;
                default: c = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 9) == 0);
            frame_and_check("random", c, bp, bs);
        end

        // Mid-frame reset: force a non-zero mode and character first, so the reset is observable.
        frame_and_check("pre-rst F2 a", 8'h06, 0, 0);
        frame_and_check("pre-rst F2 b", 8'h06, 0, 0);
        frame_and_check("pre-rst char", 8'h3A, 0, 0);
        evq.delete();
        bits = make_frame(8'h1C, 0, 0);
        send_bits(bits, 0, 4);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check("async rst character", bus.character, 8'h00);
        check("async rst mode", bus.mode, 2'd0);
        check("async rst strobes", {bus.char_check, bus.colour_check, bus.move_check}, 3'b000);
        check("async rst frame_error", bus.frame_error, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send_bits(bits, 5, 10);
        repeat (TIMEOUT + 20) @(negedge clk);
        // Any 0 among the leftover bits starts a frame that can never complete, so it must time out.
        exp_err = 0;
        for (int i = 5; i <= 10; i++) if (bits[i] == 1'b0) exp_err = 1;
        check("post-rst events", evq.size(), exp_err);
        if (evq.size() == 1) check("post-rst kind", evq[0].kind, 3);
        check_outputs("post-rst");

        check("one-hot strobes", multi_hot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_command_receiver.md
# ps2_command_receiver

Receives PS/2 keyboard frames and turns them into the command strobes and character byte consumed by the iTalos display path (`character`, `char_check`, `colour_check`, `move_check`). Sits between the keyboard pins and the display controller in the `clk` domain. Mode keys F1/F2/F3 select which strobe later key presses fire. Break (release) codes are discarded, as are extended prefixes.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; used only to size the timeout.
- `TIMEOUT_CYCLES`, 50_000: `clk` cycles with no PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock; one clock; reset is asynchronous and active-low.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw keyboard clock, asynchronous.
- `ps2_data`  in  1  raw keyboard data, asynchronous.
- `character`  out  8  last accepted data-key scan code, held until the next one.
- `char_check`  out  1  one-cycle strobe: `character` is a glyph to display (mode CHAR).
- `colour_check`  out  1  one-cycle strobe: `character` selects a colour (mode COLOUR).
- `move_check`  out  1  one-cycle strobe: `character` is a move command (mode MOVE).
- `mode`  out  2  current mode: 0 = CHAR, 1 = COLOUR, 2 = MOVE.
- `frame_error`  out  1  one-cycle strobe on a parity or stop-bit failure, or on a timeout.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through 2 flops. A falling edge is detected when the synced clock was 1 on the previous cycle and is 0 on this one. Data is sampled on the detect cycle.
- **Frame format:** 11 bits. Start bit = 0, then 8 data bits LSB first, then odd parity, then stop bit = 1.
- **FSM states:** IDLE, SHIFT, CHECK.
  - IDLE: on a falling edge with data 0, clear the 4-bit bit counter and go to SHIFT. A falling edge with data 1 is ignored (glitch); no error is raised.
  - SHIFT: on each falling edge, shift the sampled bit into a 10-bit register and increment the bit counter. When the counter reaches 10 (data + parity + stop captured), go to CHECK.
  - CHECK: one cycle. The frame is valid when the XOR of the 8 data bits and the parity bit is 1 and the stop bit is 1. Valid frames go to decode; invalid frames pulse `frame_error` and clear both prefix flags. Always returns to IDLE.
- **Timeout:** a down-counter is reloaded with `TIMEOUT_CYCLES` on every falling edge, and counts only in SHIFT. If it reaches 0 in SHIFT, pulse `frame_error`, clear the prefix flags, and go to IDLE.
- **Decode** (valid frames only):
  - 0xE0: set the `ext` flag; no output.
  - 0xF0: set the `brk` flag; no output.
  - Any other code with `brk` or `ext` set: discard, clear both flags.
  - 0x05 (F1): mode = 0. 0x06 (F2): mode = 1. 0x04 (F3): mode = 2. No strobe.
  - Any other code: load `character`, then fire the strobe selected by `mode`.
- Exactly one strobe can be high in any cycle. `character` is updated in the same cycle its strobe rises.

## Timing
- Reset values: `character` = 0x00, all strobes = 0, `mode` = 0, `frame_error` = 0, FSM = IDLE, `ext` = `brk` = 0, timeout counter = `TIMEOUT_CYCLES`, sync flops = 1.
- Latency: strobe / `frame_error` is high exactly 2 `clk` cycles after the edge-detect cycle of the stop bit (CHECK, then registered output). That is 4–5 cycles after the raw `ps2_clk` fall, given sync plus detect.
- Strobes are always 1 cycle wide. No handshake: the consumer must accept on the strobe cycle.
- A mode change takes effect for the next data key; a key in the same frame cannot be affected.
- Reset asserted mid-frame aborts the frame immediately. After release, the receiver waits for a new start bit; the partial frame's remaining edges are then parsed as a new frame and caught by parity/stop/timeout.
- Minimum supported `clk`/`ps2_clk` ratio is 8.

## Test plan
- Reset, then a frame with code 0x1C, parity 0 (0x1C has three ones) → `character` = 0x1C, `char_check` high for 1 cycle, `mode` = 0, no error.
- Frame 0x06 (F2), then frame 0x2D → `mode` = 1; `colour_check` pulses once with `character` = 0x2D; `char_check` stays 0.
- Frames 0xF0 then 0x2D, then 0x2D → no strobe for the first 0x2D; the second 0x2D strobes `colour_check` (mode 1). Repeat with 0xE0 0x75: no strobe.
- Frame 0x1C with wrong parity (1), and separately a frame with stop bit 0 → `frame_error` pulse, `character` unchanged, no strobe. The next good frame 0x1C decodes normally.
- Send 5 bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES` + 1 (`TIMEOUT_CYCLES` = 100 in sim) → `frame_error` pulses after exactly 100 idle cycles in SHIFT. A following full frame 0x04 sets `mode` = 2.
- Assert `reset` after bit 4 of a frame → all outputs return to reset values asynchronously. Post-release garbage edges yield `frame_error` or nothing, and never a strobe with `mode` ≠ 0 state.
